// File: rtl/seq_restoring_divider_if.sv
// Valid/ready operand and result bundle for seq_restoring_divider.
// The master side produces operands and consumes results; the slave side is the divider.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, one operation in flight,
// result held in registers until the consumer takes it.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    count_q, count_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [2*WIDTH:0] rq_sh;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      count_q     <= count_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    count_d     = count_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    rq_sh = {r_q, q_q} << 1;
    trial = rq_sh[2*WIDTH:WIDTH] - {1'b0, d_q};

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          q_d     = bus.dividend;
          d_d     = bus.divisor;
          r_d     = '0;
          count_d = CW'(WIDTH);
          zero_d  = (bus.divisor == '0);
          state_d = RUN;
        end
      end
      RUN: begin
        // A zero divisor spends a single RUN cycle so its result lands one edge after accept.
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = q_q;
          dbz_d       = 1'b1;
          count_d     = '0;
          state_d     = DONE;
        end else begin
          if (!trial[WIDTH]) begin
            r_d = trial;
            q_d = {rq_sh[WIDTH-1:1], 1'b1};
          end else begin
            r_d = rq_sh[2*WIDTH:WIDTH];
            q_d = rq_sh[WIDTH-1:0];
          end
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            quotient_d  = q_d;
            remainder_d = r_d[WIDTH-1:0];
            dbz_d       = 1'b0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed vector table,
// hand-written backpressure/reset sequences and a randomized sweep against an arithmetic model.
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n;

  seq_restoring_divider_if #(.WIDTH(8)) bif ();

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
    int         stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = 255;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at #1 after a rising edge with the divider idle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall, input bit noise,
                        output logic [7:0] q, output logic [7:0] r, output logic dbz,
                        output int lat, output int ir_low);
    bif.in_valid = 1'b1;
    bif.dividend = a;
    bif.divisor  = b;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    bif.dividend = 8'($urandom);
    bif.divisor  = 8'($urandom);
    lat    = 0;
    ir_low = 0;
    while (!bif.out_valid && lat < 40) begin
      if (!bif.in_ready) ir_low++;
      if (noise) begin
        bif.in_valid  = 1'($urandom_range(0, 1));
        bif.out_ready = 1'($urandom_range(0, 1));
        bif.dividend  = 8'($urandom);
        bif.divisor   = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_seen", {31'd0, bif.out_valid}, 32'd1);
    if (!bif.in_ready) ir_low++;
    q   = bif.quotient;
    r   = bif.remainder;
    dbz = bif.div_by_zero;
    for (int i = 0; i < stall; i++) begin
      bif.out_ready = 1'b0;
      if (noise) begin
        bif.in_valid = 1'($urandom_range(0, 1));
        bif.dividend = 8'($urandom);
        bif.divisor  = 8'($urandom);
      end
      @(posedge clk); #1;
      chk("stall_out_valid", {31'd0, bif.out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, bif.in_ready}, 32'd0);
      chk("stall_quotient", {24'd0, bif.quotient}, {24'd0, q});
      chk("stall_remainder", {24'd0, bif.remainder}, {24'd0, r});
      if (!bif.in_ready) ir_low++;
    end
    bif.out_ready = 1'b1;
    if (noise) bif.in_valid = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b0;
    chk("post_hs_in_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("post_hs_out_valid", {31'd0, bif.out_valid}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[8];
    logic [7:0] q, r, a, b;
    logic       dbz;
    int         lat, ir_low, st, eq, er, bad;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8, 0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8, 0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8, 0};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8, 0};
    vecs[4] = '{8'd0,   8'd13,  8'd0,   8'd0,   1'b0, 8, 0};
    vecs[5] = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1, 1, 0};
    vecs[6] = '{8'd100, 8'd3,   8'd33,  8'd1,   1'b0, 8, 0};
    vecs[7] = '{8'd77,  8'd5,   8'd15,  8'd2,   1'b0, 8, 6};

    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.dividend  = '0;
    bif.divisor   = '0;
    #12;
    chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("rst_quotient", {24'd0, bif.quotient}, 32'd0);
    chk("rst_remainder", {24'd0, bif.remainder}, 32'd0);
    chk("rst_dbz", {31'd0, bif.div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].stall > 0, q, r, dbz, lat, ir_low);
      chk("vec_quotient", {24'd0, q}, {24'd0, vecs[i].q});
      chk("vec_remainder", {24'd0, r}, {24'd0, vecs[i].r});
      chk("vec_dbz", {31'd0, dbz}, {31'd0, vecs[i].dbz});
      chk("vec_latency", lat, vecs[i].lat);
      chk("vec_in_ready_low", ir_low, vecs[i].lat + 1 + vecs[i].stall);
    end

    // Reset in the middle of 250/3
    bif.in_valid = 1'b1;
    bif.dividend = 8'd250;
    bif.divisor  = 8'd3;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("midrst_quotient", {24'd0, bif.quotient}, 32'd0);
    chk("midrst_remainder", {24'd0, bif.remainder}, 32'd0);
    chk("midrst_dbz", {31'd0, bif.div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) bad++;
    end
    chk("postrst_idle_bad_cycles", bad, 0);
    run_op(8'd9, 8'd2, 0, 1'b0, q, r, dbz, lat, ir_low);
    chk("postrst_quotient", {24'd0, q}, 32'd4);
    chk("postrst_remainder", {24'd0, r}, 32'd1);
    chk("postrst_dbz", {31'd0, dbz}, 32'd0);

    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 8'd0;
        1:       b = 8'd1;
        2:       b = 8'd255;
        default: b = 8'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) a = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
      st = $urandom_range(0, 3);
      run_op(a, b, st, 1'b1, q, r, dbz, lat, ir_low);
      ref_div(int'(a), int'(b), eq, er);
      chk("rnd_quotient", {24'd0, q}, eq);
      chk("rnd_remainder", {24'd0, r}, er);
      chk("rnd_dbz", {31'd0, dbz}, (b == 8'd0) ? 32'd1 : 32'd0);
      chk("rnd_latency", lat, (b == 8'd0) ? 1 : 8);
      chk("rnd_in_ready_low", ir_low, lat + 1 + st);
      if (b != 8'd0)
        chk("rnd_invariant", {31'd0, (int'(a) == int'(q) * int'(b) + int'(r)) && (r < b)}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
